// File: rtl/word_selector.sv
// Hangman secret-word picker: free-running XNOR LFSR feeds a rejection-sampling
// FSM that selects one of NUM_WORDS 4-letter entries and holds it with a valid flag.
module word_selector #(
  parameter int unsigned           LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED       = '0,
  parameter int unsigned           NUM_WORDS  = 8,
  parameter bit                    NO_REPEAT  = 1'b1,
  parameter int unsigned           MAX_TRIES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  output logic       busy,
  output logic       valid,
  output logic [2:0] word_idx,
  output logic [5:0] letter1,
  output logic [5:0] letter2,
  output logic [5:0] letter3,
  output logic [5:0] letter4
);

  localparam int unsigned     IdxW      = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned     TryW      = $clog2(MAX_TRIES + 1);
  localparam logic [TryW-1:0] LastTry   = TryW'(MAX_TRIES - 1);
  localparam logic [3:0]      NumWords4 = 4'(NUM_WORDS);
  localparam logic [2:0]      LastIdx   = 3'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StPick, StDone} state_e;

  state_e                  state_q, state_d;
  logic [TryW-1:0]         tries_q, tries_d;
  logic [2:0]              word_idx_q, word_idx_d;
  logic [23:0]             letters_q, letters_d;
  logic                    have_prev_q, have_prev_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    lfsr_fb;

  logic [IdxW-1:0] cand;
  logic [2:0]      cand_idx;
  logic            in_range;
  logic            repeat_hit;
  logic            accept;
  logic            pick_done;
  logic [2:0]      fallback_idx;
  logic [2:0]      pick_idx;

  // Letter code = 0x0A + (letter - 'A'), packed letter1 in the top six bits.
  function automatic logic [23:0] word_letters(input logic [2:0] idx);
    logic [23:0] w;
    unique case (idx)
      3'd0:    w = {6'h1C, 6'h1D, 6'h0A, 6'h22};  // STAY
      3'd1:    w = {6'h0D, 6'h0A, 6'h1B, 6'h17};  // DARN
      3'd2:    w = {6'h15, 6'h12, 6'h0F, 6'h0E};  // LIFE
      3'd3:    w = {6'h11, 6'h0E, 6'h0A, 6'h0D};  // HEAD
      3'd4:    w = {6'h13, 6'h1E, 6'h16, 6'h19};  // JUMP
      3'd5:    w = {6'h20, 6'h18, 6'h15, 6'h0F};  // WOLF
      3'd6:    w = {6'h1A, 6'h1E, 6'h12, 6'h23};  // QUIZ
      default: w = {6'h0B, 6'h18, 6'h21, 6'h22};  // BOXY
    endcase
    return w;
  endfunction

  // XNOR feedback: the all-ones state is the lock-up point, so SEED must avoid it.
  if (LFSR_WIDTH == 4) begin : g_taps4
    assign lfsr_fb = ~(lfsr_q[3] ^ lfsr_q[2]);
  end else if (LFSR_WIDTH == 8) begin : g_taps8
    assign lfsr_fb = ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]);
  end else begin : g_taps16
    assign lfsr_fb = ~(lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]);
  end

  assign lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], lfsr_fb};

  always_comb begin
    cand         = lfsr_q[IdxW-1:0];
    cand_idx     = 3'(cand);
    in_range     = {1'b0, cand_idx} < NumWords4;
    repeat_hit   = NO_REPEAT && have_prev_q && (cand_idx == word_idx_q);
    accept       = in_range && !repeat_hit;
    pick_done    = accept || (tries_q == LastTry);
    fallback_idx = (word_idx_q == LastIdx) ? 3'd0 : word_idx_q + 3'd1;
    pick_idx     = accept ? cand_idx : fallback_idx;
  end

  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    word_idx_d  = word_idx_q;
    letters_d   = letters_q;
    have_prev_d = have_prev_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (req) begin
          state_d = StPick;
          tries_d = '0;
        end
      end
      StPick: begin
        // req is deliberately ignored here; it is not queued.
        if (pick_done) begin
          state_d     = StDone;
          word_idx_d  = pick_idx;
          letters_d   = word_letters(pick_idx);
          have_prev_d = 1'b1;
        end else begin
          tries_d = tries_q + TryW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      tries_q     <= '0;
      word_idx_q  <= '0;
      letters_q   <= '0;
      have_prev_q <= 1'b0;
      lfsr_q      <= SEED;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      word_idx_q  <= word_idx_d;
      letters_q   <= letters_d;
      have_prev_q <= have_prev_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign busy     = (state_q == StPick);
  assign valid    = (state_q == StDone);
  assign word_idx = word_idx_q;
  assign letter1  = letters_q[23:18];
  assign letter2  = letters_q[17:12];
  assign letter3  = letters_q[11:6];
  assign letter4  = letters_q[5:0];

endmodule

// File: tb/tb_word_selector.sv
// Bench for word_selector: five parameterisations share req/reset, checked every
// cycle against a spec-level model plus directed literal expectations.
module tb_word_selector;

  localparam int N = 5;
  localparam int P_W [N] = '{4, 4, 4, 8, 16};
  localparam int P_S [N] = '{0, 1, 0, 'h5A, 'h1234};
  localparam int P_N [N] = '{4, 3, 4, 5, 8};
  localparam int P_NR[N] = '{1, 1, 0, 1, 1};
  localparam int P_MT[N] = '{16, 4, 16, 2, 3};

  localparam int PhIdle = 0;
  localparam int PhPick = 1;
  localparam int PhDone = 2;

  localparam logic [23:0] W_DARN = {6'h0D, 6'h0A, 6'h1B, 6'h17};
  localparam logic [23:0] W_LIFE = {6'h15, 6'h12, 6'h0F, 6'h0E};
  localparam logic [23:0] W_HEAD = {6'h11, 6'h0E, 6'h0A, 6'h0D};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req   = 1'b0;

  logic       busy_w [N];
  logic       valid_w[N];
  logic [2:0] idx_w  [N];
  logic [5:0] l1_w   [N];
  logic [5:0] l2_w   [N];
  logic [5:0] l3_w   [N];
  logic [5:0] l4_w   [N];
  logic [31:0] lfsr_obs[N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  word_selector #(.LFSR_WIDTH(4), .SEED(4'h0), .NUM_WORDS(4), .NO_REPEAT(1'b1),
                  .MAX_TRIES(16)) dut0 (
    .clock(clock), .reset(reset), .req(req), .busy(busy_w[0]), .valid(valid_w[0]),
    .word_idx(idx_w[0]), .letter1(l1_w[0]), .letter2(l2_w[0]), .letter3(l3_w[0]),
    .letter4(l4_w[0]));
  word_selector #(.LFSR_WIDTH(4), .SEED(4'h1), .NUM_WORDS(3), .NO_REPEAT(1'b1),
                  .MAX_TRIES(4)) dut1 (
    .clock(clock), .reset(reset), .req(req), .busy(busy_w[1]), .valid(valid_w[1]),
    .word_idx(idx_w[1]), .letter1(l1_w[1]), .letter2(l2_w[1]), .letter3(l3_w[1]),
    .letter4(l4_w[1]));
  word_selector #(.LFSR_WIDTH(4), .SEED(4'h0), .NUM_WORDS(4), .NO_REPEAT(1'b0),
                  .MAX_TRIES(16)) dut2 (
    .clock(clock), .reset(reset), .req(req), .busy(busy_w[2]), .valid(valid_w[2]),
    .word_idx(idx_w[2]), .letter1(l1_w[2]), .letter2(l2_w[2]), .letter3(l3_w[2]),
    .letter4(l4_w[2]));
  word_selector #(.LFSR_WIDTH(8), .SEED(8'h5A), .NUM_WORDS(5), .NO_REPEAT(1'b1),
                  .MAX_TRIES(2)) dut3 (
    .clock(clock), .reset(reset), .req(req), .busy(busy_w[3]), .valid(valid_w[3]),
    .word_idx(idx_w[3]), .letter1(l1_w[3]), .letter2(l2_w[3]), .letter3(l3_w[3]),
    .letter4(l4_w[3]));
  word_selector #(.LFSR_WIDTH(16), .SEED(16'h1234), .NUM_WORDS(8), .NO_REPEAT(1'b1),
                  .MAX_TRIES(3)) dut4 (
    .clock(clock), .reset(reset), .req(req), .busy(busy_w[4]), .valid(valid_w[4]),
    .word_idx(idx_w[4]), .letter1(l1_w[4]), .letter2(l2_w[4]), .letter3(l3_w[4]),
    .letter4(l4_w[4]));

  assign lfsr_obs[0] = 32'(dut0.lfsr_q);
  assign lfsr_obs[1] = 32'(dut1.lfsr_q);
  assign lfsr_obs[2] = 32'(dut2.lfsr_q);
  assign lfsr_obs[3] = 32'(dut3.lfsr_q);
  assign lfsr_obs[4] = 32'(dut4.lfsr_q);

  // ---------------- reference model ----------------
  string words[8] = '{"STAY", "DARN", "LIFE", "HEAD", "JUMP", "WOLF", "QUIZ", "BOXY"};

  int m_lfsr [N];
  int m_phase[N];
  int m_tries[N];
  int m_idx  [N];
  bit m_prev [N];

  function automatic int lfsr_next(input int w, input int v);
    int x;
    case (w)
      4:       x = ((v >> 3) ^ (v >> 2)) & 1;
      8:       x = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      default: x = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    endcase
    return ((v << 1) | (x ^ 1)) & ((1 << w) - 1);
  endfunction

  function automatic int idx_bits(input int n);
    int b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

  function automatic logic [23:0] model_word(input int i);
    logic [23:0] w = '0;
    if (m_prev[i])
      for (int k = 0; k < 4; k++) w[23-6*k -: 6] = 6'(int'(words[m_idx[i]][k]) - 65 + 10);
    return w;
  endfunction

  task automatic model_step(input int i);
    int  cur;
    int  cand;
    bit  ok;
    if (reset) begin
      m_lfsr[i] = P_S[i]; m_phase[i] = PhIdle; m_tries[i] = 0; m_idx[i] = 0; m_prev[i] = 0;
      return;
    end
    cur       = m_lfsr[i];
    m_lfsr[i] = lfsr_next(P_W[i], cur);
    if (m_phase[i] != PhPick) begin
      if (req) begin m_phase[i] = PhPick; m_tries[i] = 0; end
    end else begin
      cand = cur % (1 << idx_bits(P_N[i]));
      ok   = (cand < P_N[i]) && !(P_NR[i] != 0 && m_prev[i] && cand == m_idx[i]);
      if (ok) begin
        m_idx[i] = cand; m_prev[i] = 1; m_phase[i] = PhDone;
      end else if (m_tries[i] == P_MT[i] - 1) begin
        m_idx[i] = (m_idx[i] + 1) % P_N[i]; m_prev[i] = 1; m_phase[i] = PhDone;
      end else begin
        m_tries[i]++;
      end
    end
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] word_obs(input int i);
    return {l1_w[i], l2_w[i], l3_w[i], l4_w[i]};
  endfunction

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("dut%0d busy", i), 32'(busy_w[i]), 32'(m_phase[i] == PhPick));
      check($sformatf("dut%0d valid", i), 32'(valid_w[i]), 32'(m_phase[i] == PhDone));
      check($sformatf("dut%0d word_idx", i), 32'(idx_w[i]), 32'(m_idx[i]));
      check($sformatf("dut%0d letters", i), 32'(word_obs(i)), 32'(model_word(i)));
      check($sformatf("dut%0d lfsr", i), lfsr_obs[i], 32'(m_lfsr[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_phase(input bit r);
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    req   = r;
    @(negedge clock);
  endtask

  task automatic nxt(input bit r);
    @(posedge clock); #1;
    req = r;
    @(negedge clock);
  endtask

  int seq[7] = '{0, 1, 3, 7, 14, 13, 11};
  bit bad;

  initial begin
    // Basic pick and LFSR order.
    start_phase(1'b1);
    check("rst valid", 32'(valid_w[0]), 0);
    check("rst busy", 32'(busy_w[0]), 0);
    check("rst idx", 32'(idx_w[0]), 0);
    check("rst letters", 32'(word_obs(0)), 0);
    check("lfsr c0", lfsr_obs[0], 32'(seq[0]));
    check("seed b", lfsr_obs[1], 1);
    nxt(1'b0);
    check("basic busy c1", 32'(busy_w[0]), 1);
    check("lfsr c1", lfsr_obs[0], 32'(seq[1]));
    check("rej busy c1", 32'(busy_w[1]), 1);
    nxt(1'b0);
    check("basic valid c2", 32'(valid_w[0]), 1);
    check("basic idx c2", 32'(idx_w[0]), 1);
    check("basic DARN", 32'(word_obs(0)), 32'(W_DARN));
    check("lfsr c2", lfsr_obs[0], 32'(seq[2]));
    check("rej busy c2", 32'(busy_w[1]), 1);
    nxt(1'b0);
    check("lfsr c3", lfsr_obs[0], 32'(seq[3]));
    check("rej busy c3", 32'(busy_w[1]), 1);
    check("rej valid c3", 32'(valid_w[1]), 0);
    nxt(1'b0);
    check("lfsr c4", lfsr_obs[0], 32'(seq[4]));
    check("rej valid c4", 32'(valid_w[1]), 1);
    check("rej busy c4", 32'(busy_w[1]), 0);
    check("rej idx c4", 32'(idx_w[1]), 2);
    check("rej LIFE", 32'(word_obs(1)), 32'(W_LIFE));
    nxt(1'b0);
    check("lfsr c5", lfsr_obs[0], 32'(seq[5]));
    nxt(1'b0);
    check("lfsr c6", lfsr_obs[0], 32'(seq[6]));
    bad = 1'b0;
    for (int c = 7; c < 15; c++) begin
      nxt(1'b0);
      if (lfsr_obs[0] == 32'd15 || lfsr_obs[0] == 32'd0) bad = 1'b1;
    end
    check("lfsr early repeat or lockup", 32'(bad), 0);
    nxt(1'b0);
    check("lfsr period 15", lfsr_obs[0], 0);

    // Back-to-back request on the first valid cycle.
    start_phase(1'b1);
    nxt(1'b0);
    nxt(1'b1);
    check("b2b valid c2", 32'(valid_w[0]), 1);
    nxt(1'b0);
    check("b2b valid c3", 32'(valid_w[0]), 0);
    check("b2b busy c3", 32'(busy_w[0]), 1);
    nxt(1'b0);
    check("b2b valid c4", 32'(valid_w[0]), 1);
    check("b2b idx c4", 32'(idx_w[0]), 3);
    check("b2b HEAD", 32'(word_obs(0)), 32'(W_HEAD));

    // No-repeat versus repeat-allowed.
    start_phase(1'b1);
    nxt(1'b0);
    nxt(1'b0);
    nxt(1'b0);
    nxt(1'b1);
    nxt(1'b0);
    check("norep busy c5", 32'(busy_w[0]), 1);
    check("rep busy c5", 32'(busy_w[2]), 1);
    nxt(1'b0);
    check("norep busy c6", 32'(busy_w[0]), 1);
    check("rep valid c6", 32'(valid_w[2]), 1);
    check("rep idx c6", 32'(idx_w[2]), 1);
    check("rep DARN", 32'(word_obs(2)), 32'(W_DARN));
    nxt(1'b0);
    check("norep valid c7", 32'(valid_w[0]), 1);
    check("norep idx c7", 32'(idx_w[0]), 3);
    check("norep HEAD", 32'(word_obs(0)), 32'(W_HEAD));

    // req held through PICK, then reset inside PICK.
    start_phase(1'b1);
    nxt(1'b1);
    nxt(1'b1);
    check("held req c2 valid", 32'(valid_w[1]), 0);
    nxt(1'b1);
    check("held req c3 valid", 32'(valid_w[1]), 0);
    nxt(1'b1);
    check("held req c4 idx", 32'(idx_w[1]), 2);
    check("held req c4 valid", 32'(valid_w[1]), 1);
    nxt(1'b1);
    check("held req c5 busy", 32'(busy_w[1]), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clock);
    check("abort valid", 32'(valid_w[1]), 0);
    check("abort busy", 32'(busy_w[1]), 0);
    check("abort idx", 32'(idx_w[1]), 0);
    check("abort letters", 32'(word_obs(1)), 0);
    check("abort lfsr", lfsr_obs[1], 1);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 149) == 0);
      req   = ($urandom_range(0, 99) < 35);
    end
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
